// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle integer ops plus iterative radix-2 MUL/MULHU and
// restoring DIVU/REMU, with a registered result and branch flag behind valid/ready.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int LANES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [4:0]       op,
  input  logic             lane_mode,
  input  logic             invert_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             take_branch
);

  localparam int SW = $clog2(WIDTH);
  localparam int LW = WIDTH / LANES;
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  localparam logic [4:0] OP_A     = 5'd1;
  localparam logic [4:0] OP_B     = 5'd2;
  localparam logic [4:0] OP_ADD   = 5'd3;
  localparam logic [4:0] OP_SUB   = 5'd4;
  localparam logic [4:0] OP_AND   = 5'd5;
  localparam logic [4:0] OP_OR    = 5'd6;
  localparam logic [4:0] OP_XOR   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_SLL   = 5'd10;
  localparam logic [4:0] OP_SRL   = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12;
  localparam logic [4:0] OP_EQUAL = 5'd13;
  localparam logic [4:0] OP_MUL   = 5'd14;
  localparam logic [4:0] OP_MULHU = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_REMU  = 5'd17;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [SW-1:0]    count;
  logic [4:0]       op_q;
  logic             inv_q;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             accept;
  logic             is_iter;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] lane_sum;
  logic [WIDTH-1:0] lane_diff;
  logic [WIDTH-1:0] quick;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   r_shift;
  logic             div_ge;
  logic [WIDTH-1:0] next_hi;
  logic [WIDTH-1:0] next_lo;
  logic [WIDTH-1:0] iter_res;
  logic             is_div;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; the producer holds its payload until then, and flush blocks acceptance.
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign is_iter  = (op >= OP_MUL) && (op <= OP_REMU);
  assign shamt    = src_b[SW-1:0];
  assign is_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);

  always_comb begin
    lane_sum  = '0;
    lane_diff = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum[i*LW +: LW]  = src_a[i*LW +: LW] + src_b[i*LW +: LW];
      lane_diff[i*LW +: LW] = src_a[i*LW +: LW] - src_b[i*LW +: LW];
    end
  end

  always_comb begin
    quick = '0;
    case (op)
      OP_A:     quick = src_a;
      OP_B:     quick = src_b;
      OP_ADD:   quick = lane_mode ? lane_sum : src_a + src_b;
      OP_SUB:   quick = lane_mode ? lane_diff : src_a - src_b;
      OP_AND:   quick = src_a & src_b;
      OP_OR:    quick = src_a | src_b;
      OP_XOR:   quick = src_a ^ src_b;
      OP_SLT:   quick = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU:  quick = {{(WIDTH-1){1'b0}}, src_a < src_b};
      OP_SLL:   quick = src_a << shamt;
      OP_SRL:   quick = src_a >> shamt;
      OP_SRA:   quick = $signed(src_a) >>> shamt;
      OP_EQUAL: quick = {{(WIDTH-1){1'b0}}, src_a == src_b};
      default:  quick = '0;
    endcase
  end

  // acc_hi/acc_lo hold {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    r_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge  = r_shift >= {1'b0, operand};
    if (is_div) begin
      next_hi = div_ge ? r_shift[WIDTH-1:0] - operand : r_shift[WIDTH-1:0];
      next_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      next_hi = mul_sum[WIDTH:1];
      next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    iter_res = (op_q == OP_MULHU || op_q == OP_REMU) ? next_hi : next_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      op_q        <= '0;
      inv_q       <= 1'b0;
      operand     <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      take_branch <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q  <= op;
            inv_q <= invert_cond;
            count <= '0;
            if (is_iter) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              operand   <= src_b;
              acc_hi    <= '0;
              acc_lo    <= src_a;
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              result      <= quick;
              take_branch <= quick[0] ^ invert_cond;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          acc_hi <= next_hi;
          acc_lo <= next_lo;
          if (count == LAST) begin
            state       <= DONE;
            count       <= '0;
            out_valid   <= 1'b1;
            result      <= iter_res;
            take_branch <= iter_res[0] ^ inv_q;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand sequences for backpressure,
// flush and reset, then random ops scored against an arithmetic reference model.
module tb_alu_seq;

  localparam int W     = 32;
  localparam int LANES = 2;
  localparam int LW    = W / LANES;
  localparam int MLAT  = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [4:0]   op;
  logic         lane_mode;
  logic         invert_cond;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         take_branch;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [4:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         lm;
    logic         inv;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  alu_seq #(.WIDTH(W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .op(op), .lane_mode(lane_mode),
    .invert_cond(invert_cond), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .take_branch(take_branch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_model(input logic [4:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic lm);
    longint unsigned ua, ub, m, r, lmod, la, lb, lr;
    longint sa, sb;
    int sh;
    ua = 64'(a);
    ub = 64'(b);
    m  = 64'd1 << W;
    sa = a[W-1] ? longint'(ua) - longint'(m) : longint'(ua);
    sb = b[W-1] ? longint'(ub) - longint'(m) : longint'(ub);
    sh = int'(ub % 64'(W));
    r  = 0;
    case (int'(o))
      1: r = ua;
      2: r = ub;
      3, 4: begin
        if (lm) begin
          lmod = 64'd1 << LW;
          for (int l = 0; l < LANES; l++) begin
            la = (ua >> (l * LW)) % lmod;
            lb = (ub >> (l * LW)) % lmod;
            lr = (o == 5'd3) ? (la + lb) % lmod : (la + lmod - lb) % lmod;
            r  = r + (lr << (l * LW));
          end
        end else begin
          r = (o == 5'd3) ? (ua + ub) % m : (ua + m - ub) % m;
        end
      end
      5:  r = ua & ub;
      6:  r = ua | ub;
      7:  r = ua ^ ub;
      8:  r = (sa < sb) ? 64'd1 : 64'd0;
      9:  r = (ua < ub) ? 64'd1 : 64'd0;
      10: r = (ua << sh) % m;
      11: r = ua >> sh;
      12: begin r = 64'(sa >>> sh); r = r % m; end
      13: r = (ua == ub) ? 64'd1 : 64'd0;
      14: r = (ua * ub) % m;
      15: r = (ua * ub) / m;
      16: r = (ub == 0) ? m - 1 : ua / ub;
      17: r = (ub == 0) ? ua : ua % ub;
      default: r = 0;
    endcase
    return W'(r);
  endfunction

  // Issues one op, scrambles the inputs after acceptance, waits for out_valid,
  // optionally stalls the consumer for hold cycles, then completes the handshake.
  task automatic run_op(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic lm, input logic inv, input int hold,
                        output logic [W-1:0] r, output logic t, output int lat,
                        output int rdy_busy);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check("in_ready_timeout", 64'(in_ready), 64'd1);
    op = o; src_a = a; src_b = b; lane_mode = lm; invert_cond = inv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 5'($urandom); src_a = $urandom; src_b = $urandom;
    lane_mode = 1'($urandom); invert_cond = 1'($urandom);
    lat = 1;
    rdy_busy = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy++;
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    t = take_branch;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_stable", 64'({out_valid, take_branch, result}), 64'({1'b1, t, r}));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r, e;
    logic         t;
    int           lat, rdy_busy, seen;
    logic [4:0]   o;
    logic [W-1:0] a, b;
    logic         lm, inv;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    src_a = '0; src_b = '0; op = '0; lane_mode = 1'b0; invert_cond = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_take_branch", 64'(take_branch), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{5'd3,  32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1});
    vecs.push_back('{5'd3,  32'h0001FFFF, 32'h00010001, 1'b1, 1'b0, 32'h00020000, 1});
    vecs.push_back('{5'd4,  32'h00000000, 32'h00010001, 1'b1, 1'b0, 32'hFFFFFFFF, 1});
    vecs.push_back('{5'd4,  32'h00000000, 32'h00010001, 1'b0, 1'b0, 32'hFFFEFFFF, 1});
    vecs.push_back('{5'd3,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000, 1});
    vecs.push_back('{5'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, MLAT});
    vecs.push_back('{5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001, MLAT});
    vecs.push_back('{5'd14, 32'h00010003, 32'h00000005, 1'b1, 1'b0, 32'h0005000F, MLAT});
    vecs.push_back('{5'd16, 32'd100,      32'd7,        1'b0, 1'b0, 32'd14,        MLAT});
    vecs.push_back('{5'd17, 32'd100,      32'd7,        1'b0, 1'b0, 32'd2,         MLAT});
    vecs.push_back('{5'd16, 32'd5,        32'd0,        1'b0, 1'b0, 32'hFFFFFFFF, MLAT});
    vecs.push_back('{5'd17, 32'd5,        32'd0,        1'b0, 1'b1, 32'd5,         MLAT});
    vecs.push_back('{5'd16, 32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'hFFFFFFFF, MLAT});
    vecs.push_back('{5'd13, 32'd5,        32'd5,        1'b0, 1'b1, 32'd1,         1});
    vecs.push_back('{5'd13, 32'd5,        32'd6,        1'b0, 1'b1, 32'd0,         1});
    vecs.push_back('{5'd8,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'd1,         1});
    vecs.push_back('{5'd9,  32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'd0,         1});
    vecs.push_back('{5'd12, 32'h80000000, 32'h00000024, 1'b0, 1'b0, 32'hF8000000, 1});
    vecs.push_back('{5'd11, 32'h80000000, 32'h00000024, 1'b0, 1'b0, 32'h08000000, 1});
    vecs.push_back('{5'd10, 32'h00000001, 32'h00000021, 1'b0, 1'b0, 32'h00000002, 1});
    vecs.push_back('{5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 32'hF000F000, 1});
    vecs.push_back('{5'd6,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'hFFF0FFF0, 1});
    vecs.push_back('{5'd7,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b1, 32'h0FF00FF0, 1});
    vecs.push_back('{5'd1,  32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'h12345678, 1});
    vecs.push_back('{5'd2,  32'h12345678, 32'h9ABCDEF1, 1'b0, 1'b0, 32'h9ABCDEF1, 1});
    vecs.push_back('{5'd0,  32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 32'd0,         1});
    vecs.push_back('{5'd18, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'd0,         1});
    vecs.push_back('{5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0,         1});

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].lm, vecs[i].inv, 0, r, t, lat, rdy_busy);
      check($sformatf("vec%0d_result", i), 64'(r), 64'(vecs[i].exp));
      check($sformatf("vec%0d_branch", i), 64'(t), 64'(vecs[i].exp[0] ^ vecs[i].inv));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_busy_ready", i), 64'(rdy_busy), 64'd0);
    end

    // EQUAL with inverted branch, consumer stalls 4 cycles, then back-to-back accept.
    op = 5'd13; src_a = 32'd5; src_b = 32'd5; invert_cond = 1'b1; lane_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; src_a = $urandom; invert_cond = 1'b0;
    check("b2b_first_valid", 64'(out_valid), 64'd1);
    check("b2b_first_result", 64'(result), 64'd1);
    check("b2b_first_branch", 64'(take_branch), 64'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("b2b_stall_stable", 64'({out_valid, in_ready, take_branch, result}),
            64'({1'b1, 1'b0, 1'b0, 32'd1}));
    end
    op = 5'd3; src_a = 32'd2; src_b = 32'd3; invert_cond = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_result", 64'(result), 64'd5);
    check("b2b_second_branch", 64'(take_branch), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_drained", 64'(out_valid), 64'd0);

    // Flush 10 cycles into a DIVU, with an op offered in the flush cycle.
    op = 5'd16; src_a = 32'd1000; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; op = 5'd3; src_a = 32'd40; src_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    check("flush_result_held", 64'(result), 64'd5);

    // Flush while a finished result waits for the consumer.
    op = 5'd3; src_a = 32'd7; src_b = 32'd8; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("done_flush_pre", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_dropped", 64'(out_valid), 64'd0);
    check("done_flush_in_ready", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of a MUL.
    op = 5'd14; src_a = 32'hFFFFFFFF; src_b = 32'h3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    check("async_rst_branch", 64'(take_branch), 64'd0);
    #2 rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("async_rst_no_result", 64'(seen), 64'd0);

    for (int n = 0; n < 150; n++) begin
      o = 5'($urandom_range(0, 31));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = b;
      lm  = 1'($urandom);
      inv = 1'($urandom);
      exp_q.push_back(ref_model(o, a, b, lm));
      run_op(o, a, b, lm, inv, $urandom_range(0, 2), r, t, lat, rdy_busy);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_op%0d_result", n, o), 64'(r), 64'(e));
      check($sformatf("rand%0d_op%0d_branch", n, o), 64'(t), 64'(e[0] ^ inv));
      check($sformatf("rand%0d_op%0d_latency", n, o), 64'(lat),
            64'((o >= 5'd14 && o <= 5'd17) ? MLAT : 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
